fetch_pc_seq: RTL and testbench



---
 rtl/fetch_pc_seq_pkg.sv | 27 ++
 rtl/fetch_pc_seq_if.sv | 52 +++++
 rtl/fetch_pc_seq.sv | 178 +++++++++++++++++
 tb/tb_fetch_pc_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_seq_pkg.sv
// Shared fetch-core definitions: FSM state encoding, instruction geometry, bubble encoding.
// The S_TRAP state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pc_seq_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INST_BYTES   = 4;

  // Canonical NOP (addi x0, x0, 0) that decode uses when it has to insert a bubble.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP = 3'd4
`endif
  } fetch_state_e;

  // A target is misaligned when either of its two byte-offset bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/fetch_pc_seq_if.sv
// Bundles the branch-control redirect, instruction-memory and decode handshake signals
// of the fetch sequencer; master is the sequencer side, slave is the environment side.
interface fetch_pc_seq_if
  import fetch_pc_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            i_redirect;
  logic [XLEN-1:0] i_target;

  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_rvalid;
  logic [XLEN-1:0] i_imem_rdata;

  logic            o_inst_valid;
  logic [XLEN-1:0] o_inst;
  logic [XLEN-1:0] o_inst_pc;
  logic            i_inst_ready;

  logic            o_misalign;

  modport master (
    input  i_redirect,
    input  i_target,
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc,
    input  i_inst_ready,
    output o_misalign
  );

  modport slave (
    output i_redirect,
    output i_target,
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_rvalid,
    output i_imem_rdata,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc,
    output i_inst_ready,
    input  o_misalign
  );

endinterface

// File: rtl/fetch_pc_seq.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem requests and
// presents fetched words to decode. FETCH_MISALIGN_TRAP_EN enables the sticky misalign trap.
module fetch_pc_seq
  import fetch_pc_seq_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(32'h0000_0000)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fetch_pc_seq_if.master bus
);

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] pc_inc_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] inst_s;
  logic [XLEN-1:0] inst_pc_r;
  logic [XLEN-1:0] inst_pc_s;
  logic            inst_valid_r;
  logic            inst_valid_s;
  logic            trap_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_r;
  logic            misalign_s;

  // A misaligned redirect never reaches the PC; it diverts the sequencer into the trap.
  assign target_s = bus.i_target;
  assign trap_s   = bus.i_redirect & is_misaligned(bus.i_target[1:0]);
`else
  // Without the trap, the byte-offset bits of a redirect target are simply dropped.
  assign target_s = bus.i_target & ~XLEN'(2'b11);
  assign trap_s   = 1'b0;
`endif

  // Sequential fetch address; the add wraps modulo 2^XLEN.
  assign pc_inc_s = pc_r + XLEN'(INST_BYTES);

  // A request leaves only from idle, and a same-cycle redirect wins over the old PC.
  assign bus.o_imem_req  = (state_r == S_IDLE) & ~bus.i_redirect & ~i_rst;
  assign bus.o_imem_addr = pc_r;

  assign bus.o_inst_valid = inst_valid_r;
  assign bus.o_inst       = inst_r;
  assign bus.o_inst_pc    = inst_pc_r;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.o_misalign   = misalign_r;
`else
  assign bus.o_misalign   = 1'b0;
`endif

  // Next-state, next-PC and decode-output register update.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_s   = misalign_r;
`endif

    if (trap_s) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_s   = 1'b1;
      state_s      = S_TRAP;
`endif
      inst_valid_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.i_redirect) begin
            pc_s = target_s;
          end else begin
            state_s = S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.i_redirect) begin
            pc_s = target_s;
            // Without the response in hand we must still swallow it later.
            if (bus.i_imem_rvalid) begin
              state_s = S_IDLE;
            end else begin
              state_s = S_DROP;
            end
          end else if (bus.i_imem_rvalid) begin
            inst_s       = bus.i_imem_rdata;
            inst_pc_s    = pc_r;
            inst_valid_s = 1'b1;
            pc_s         = pc_inc_s;
            state_s      = S_HOLD;
          end else begin
            state_s = S_WAIT;
          end
        end

        S_HOLD: begin
          if (bus.i_redirect) begin
            inst_valid_s = 1'b0;
            pc_s         = target_s;
            state_s      = S_IDLE;
          end else if (bus.i_inst_ready) begin
            inst_valid_s = 1'b0;
            state_s      = S_IDLE;
          end else begin
            state_s = S_HOLD;
          end
        end

        S_DROP: begin
          if (bus.i_redirect) begin
            pc_s = target_s;
          end else begin
            pc_s = pc_r;
          end
          if (bus.i_imem_rvalid) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_DROP;
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: begin
          state_s = S_TRAP;
        end
`endif

        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // FSM state and program counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_IDLE;
      pc_r    <= RESET_ADDR;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Registered decode-facing outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_r       <= '0;
      inst_pc_r    <= '0;
      inst_valid_r <= 1'b0;
    end else begin
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_s;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Bench for fetch_pc_seq: directed vector table, hand-written redirect/hold/wrap/trap
// sequences and a randomized run checked against a transaction-level reference model.
module tb_fetch_pc_seq;

  logic clk;
  logic rst;

  fetch_pc_seq_if #(.XLEN(32)) bus ();

  fetch_pc_seq #(.XLEN(32), .RESET_ADDR(32'h0000_0000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: fetch bookkeeping in terms of "request outstanding / answer to be
  // discarded / instruction held for decode / trapped".
  logic [31:0] m_pc;
  bit          m_out, m_disc, m_held, m_trap, m_mis;
  logic [31:0] m_inst, m_ipc;

  // Memory model: one pending request, answered after a fixed or random latency.
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_fixed;
  bit          spur_en;

  bit          req_seen, valid_seen;
  logic [31:0] last_req_addr, valid_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic cycle(input bit r, input bit redir, input logic [31:0] tgt, input bit rdy);
    bit          rv;
    bit          exp_req;
    logic [31:0] rd;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (mem_pending) begin
      if (mem_cnt <= 1) begin
        rv = 1'b1;
        rd = mem_word(mem_addr);
        mem_pending = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (spur_en && !m_out && $urandom_range(0, 7) == 0) begin
      rv = 1'b1;
    end
    rst               = r;
    bus.i_redirect    = redir;
    bus.i_target      = tgt;
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = rd;
    bus.i_inst_ready  = rdy;
    #1;
    exp_req = !r && !m_out && !m_held && !m_trap && !redir;
    check("imem_req", bus.o_imem_req, exp_req);
    if (exp_req) check("imem_addr", bus.o_imem_addr, m_pc);
    check("inst_valid", bus.o_inst_valid, m_held);
    if (m_held) begin
      check("inst", bus.o_inst, m_inst);
      check("inst_pc", bus.o_inst_pc, m_ipc);
    end
    check("misalign", bus.o_misalign, m_mis);
    req_seen   = bus.o_imem_req;
    valid_seen = bus.o_inst_valid;
    valid_pc   = bus.o_inst_pc;
    if (req_seen) begin
      last_req_addr = bus.o_imem_addr;
      mem_pending   = 1'b1;
      mem_addr      = bus.o_imem_addr;
      mem_cnt       = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
    end
    // Advance the model by one clock.
    if (r) begin
      m_pc = 32'h0; m_out = 0; m_disc = 0; m_held = 0; m_trap = 0; m_mis = 0;
      m_inst = 32'h0; m_ipc = 32'h0;
    end else if (!m_trap) begin
      if (redir && MIS_EN && tgt[1:0] != 2'b00) begin
        m_trap = 1; m_mis = 1; m_held = 0;
      end else if (redir) begin
        m_pc   = tgt & 32'hFFFF_FFFC;
        m_held = 0;
        if (m_out && rv) m_out = 0;
        m_disc = m_out;
      end else if (exp_req) begin
        m_out = 1; m_disc = 0;
      end else if (m_out && rv) begin
        m_out = 0;
        if (!m_disc) begin
          m_held = 1; m_inst = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (m_held && rdy) begin
        m_held = 0;
      end
    end
  endtask

  task automatic reset_seq(input int lat);
    lat_fixed   = lat;
    mem_pending = 1'b0;
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wait_valid(input bit rdy, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cycle(1'b0, 1'b0, 32'h0, rdy);
      ok = valid_seen;
    end
    check({name, " valid timeout"}, ok, 1'b1);
  endtask

  task automatic wait_req(input string name, output logic [31:0] addr);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      ok = req_seen;
    end
    check({name, " req timeout"}, ok, 1'b1);
    addr = last_req_addr;
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] tgt;
    bit          rvalid;
    logic [31:0] rdata;
    bit          ready;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    bit          chk_data;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [31:0] a;
    int          cnt;
    // Reset, L=1, ready high: fetch 0x11/0x22/0x33 from 0x0/0x4/0x8.
    vt[0]  = '{1, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 0, 1, 32'h0,  32'h0};
    vt[1]  = '{0, 0, 32'h0, 0, 32'h0,  1, 1, 32'h0, 0, 0, 32'h0,  32'h0};
    vt[2]  = '{0, 0, 32'h0, 1, 32'h11, 1, 0, 32'h0, 0, 0, 32'h0,  32'h0};
    vt[3]  = '{0, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 1, 1, 32'h11, 32'h0};
    vt[4]  = '{0, 0, 32'h0, 0, 32'h0,  1, 1, 32'h4, 0, 0, 32'h0,  32'h0};
    vt[5]  = '{0, 0, 32'h0, 1, 32'h22, 1, 0, 32'h0, 0, 0, 32'h0,  32'h0};
    vt[6]  = '{0, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 1, 1, 32'h22, 32'h4};
    vt[7]  = '{0, 0, 32'h0, 0, 32'h0,  1, 1, 32'h8, 0, 0, 32'h0,  32'h0};
    vt[8]  = '{0, 0, 32'h0, 1, 32'h33, 1, 0, 32'h0, 0, 0, 32'h0,  32'h0};
    vt[9]  = '{0, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 1, 1, 32'h33, 32'h8};
    vt[10] = '{0, 0, 32'h0, 0, 32'h0,  1, 1, 32'hC, 0, 0, 32'h0,  32'h0};

    rst = 1'b1;
    bus.i_redirect = 1'b0; bus.i_target = 32'h0; bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata = 32'h0; bus.i_inst_ready = 1'b0;
    spur_en = 1'b0; mem_pending = 1'b0; lat_fixed = 1;
    m_pc = 32'h0; m_out = 0; m_disc = 0; m_held = 0; m_trap = 0; m_mis = 0;
    m_inst = 32'h0; m_ipc = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst               = vt[i].rst;
      bus.i_redirect    = vt[i].redir;
      bus.i_target      = vt[i].tgt;
      bus.i_imem_rvalid = vt[i].rvalid;
      bus.i_imem_rdata  = vt[i].rdata;
      bus.i_inst_ready  = vt[i].ready;
      #1;
      check($sformatf("row%0d req", i), bus.o_imem_req, vt[i].e_req);
      if (vt[i].e_req) check($sformatf("row%0d addr", i), bus.o_imem_addr, vt[i].e_addr);
      check($sformatf("row%0d valid", i), bus.o_inst_valid, vt[i].e_valid);
      if (vt[i].chk_data) begin
        check($sformatf("row%0d inst", i), bus.o_inst, vt[i].e_inst);
        check($sformatf("row%0d inst_pc", i), bus.o_inst_pc, vt[i].e_ipc);
      end
    end

    // Decode stalls five cycles: held word stays put, no new request until accepted.
    reset_seq(2);
    wait_valid(1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check("hold inst", bus.o_inst, mem_word(32'h0));
      check("hold pc", bus.o_inst_pc, 32'h0);
      check("hold no req", req_seen, 1'b0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("hold next req", req_seen, 1'b1);
    check("hold next addr", last_req_addr, 32'h4);

    // Redirect while the L=3 fetch of 0x8 is outstanding: stale word dropped.
    reset_seq(3);
    a = 32'h0;
    for (int i = 0; i < 40 && !(req_seen && last_req_addr == 32'h8); i++)
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("drop saw req 0x8", last_req_addr, 32'h8);
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    cnt = 0;
    req_seen = 1'b0;
    for (int i = 0; i < 10 && !req_seen; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (valid_seen && valid_pc == 32'h8) cnt++;
    end
    check("drop next addr", last_req_addr, 32'h100);
    check("drop no valid for 0x8", cnt, 0);

    // Redirect in the same cycle as the response.
    reset_seq(2);
    wait_req("rv+redir", a);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("rv+redir valid", valid_seen, 1'b0);
    check("rv+redir req", req_seen, 1'b1);
    check("rv+redir addr", last_req_addr, 32'h200);

    // Redirect while holding, with ready also high: redirect wins.
    reset_seq(1);
    wait_valid(1'b0, "hold+redir");
    cycle(1'b0, 1'b1, 32'h200, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("hold+redir valid", valid_seen, 1'b0);
    check("hold+redir addr", last_req_addr, 32'h200);

    // PC wrap from the top of the address space.
    reset_seq(1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap first addr", last_req_addr, 32'hFFFF_FFFC);
    req_seen = 1'b0;
    for (int i = 0; i < 10 && !req_seen; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap next addr", last_req_addr, 32'h0);

    // Misaligned redirect target.
    reset_seq(1);
    cycle(1'b0, 1'b1, 32'h102, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap misalign", bus.o_misalign, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, (i == 2), 32'h300, 1'b1);
      if (req_seen) cnt++;
    end
    check("trap no requests", cnt, 0);
`else
    check("unaligned req", req_seen, 1'b1);
    check("unaligned addr", last_req_addr, 32'h100);
`endif

    // Reset with a request outstanding; its answer arrives while idle and is ignored.
    reset_seq(2);
    wait_req("mid-reset", a);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("post-reset req", req_seen, 1'b1);
    check("post-reset addr", last_req_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("post-reset no valid", valid_seen, 1'b0);

    // Randomized traffic against the reference model.
    reset_seq(0);
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), t,
            ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
